// File: rtl/link_monitor.sv
// UART link supervisor: schedules heartbeat requests for the TX arbiter and runs
// a DOWN/LOCKING/UP lock-and-timeout FSM on the bytes popped from the RX FIFO.
module link_monitor #(
   parameter int         HB_PERIOD = 6_500_000,
   parameter int         TIMEOUT   = 32_500_000,
   parameter int         LOCK_CNT  = 3,
   parameter logic [7:0] HB_BYTE   = 8'hAF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_pop,
   input  logic [7:0] rx_data,
   input  logic       tx_full,
   input  logic       hb_grant,
   output logic       hb_req,
   output logic [7:0] hb_data,
   output logic       link_up,
   output logic       link_lost,
   output logic [3:0] lock_level
);

   localparam int PW = $clog2(HB_PERIOD);
   localparam int WW = $clog2(TIMEOUT);
   localparam logic [PW-1:0] PERIOD_LAST = PW'(HB_PERIOD - 1);
   localparam logic [WW-1:0] WD_LAST     = WW'(TIMEOUT - 1);
   localparam logic [3:0]    LOCK_TARGET = 4'(LOCK_CNT);

   typedef enum logic [1:0] {DOWN, LOCKING, UP} state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   period_q, period_d;
   logic [WW-1:0]   wd_q, wd_d;
   logic [3:0]      level_q, level_d;
   logic            hb_req_q, hb_req_d;
   logic            link_up_q, link_up_d;
   logic            link_lost_q, link_lost_d;
   logic            is_hb, accept, period_end, wd_expired;

   assign is_hb      = rx_pop & (rx_data == HB_BYTE);
   assign accept     = hb_req_q & hb_grant & ~tx_full;
   assign period_end = (period_q == PERIOD_LAST);
   // A byte arriving in the expiry cycle always rescues the link.
   assign wd_expired = (state_q != DOWN) & (wd_q == WD_LAST) & ~rx_pop;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= DOWN;
         period_q    <= '0;
         wd_q        <= '0;
         level_q     <= '0;
         hb_req_q    <= 1'b0;
         link_up_q   <= 1'b0;
         link_lost_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         period_q    <= period_d;
         wd_q        <= wd_d;
         level_q     <= level_d;
         hb_req_q    <= hb_req_d;
         link_up_q   <= link_up_d;
         link_lost_q <= link_lost_d;
      end
   end

   // A fresh period expiry takes priority over a same-cycle accept, so a request is never lost.
   always_comb begin
      period_d = period_end ? '0 : period_q + PW'(1);
      hb_req_d = hb_req_q;
      if (accept)
         hb_req_d = 1'b0;
      if (period_end)
         hb_req_d = 1'b1;
      wd_d = (state_q == DOWN || rx_pop || wd_expired) ? '0 : wd_q + WW'(1);
   end

   always_comb begin
      state_d = state_q;
      level_d = level_q;
      case (state_q)
         DOWN: begin
            if (is_hb) begin
               level_d = 4'd1;
               state_d = (LOCK_TARGET == 4'd1) ? UP : LOCKING;
            end
         end
         LOCKING: begin
            if (wd_expired) begin
               state_d = DOWN;
               level_d = '0;
            end else if (is_hb) begin
               level_d = level_q + 4'd1;
               if (level_q + 4'd1 >= LOCK_TARGET)
                  state_d = UP;
            end else if (rx_pop) begin
               state_d = DOWN;
               level_d = '0;
            end
         end
         UP: begin
            if (wd_expired) begin
               state_d = DOWN;
               level_d = '0;
            end
         end
         default: begin
            state_d = DOWN;
            level_d = '0;
         end
      endcase
   end

   // link_up lags entry into UP by one edge but drops together with the exit.
   always_comb begin
      link_up_d   = (state_q == UP) && (state_d == UP);
      link_lost_d = (state_q == UP) && (state_d == DOWN);
      hb_data     = hb_req_q ? HB_BYTE : 8'h00;
   end

   assign hb_req     = hb_req_q;
   assign link_up    = link_up_q;
   assign link_lost  = link_lost_q;
   assign lock_level = level_q;

endmodule

// File: tb/tb_link_monitor.sv
// Self-checking bench for link_monitor: a cycle-level behavioural model checked
// every cycle, plus hand-computed checkpoints along a directed scenario.
module tb_link_monitor;

   localparam int HB_PERIOD = 10;
   localparam int TIMEOUT   = 50;
   localparam int LOCK_CNT  = 3;

   logic       clk, rst, rx_pop, tx_full, hb_grant;
   logic [7:0] rx_data;
   logic       hb_req, link_up, link_lost;
   logic [7:0] hb_data;
   logic [3:0] lock_level;

   int checks = 0;
   int errors = 0;

   link_monitor #(
      .HB_PERIOD(HB_PERIOD),
      .TIMEOUT  (TIMEOUT),
      .LOCK_CNT (LOCK_CNT),
      .HB_BYTE  (8'hAF)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_pop    (rx_pop),
      .rx_data   (rx_data),
      .tx_full   (tx_full),
      .hb_grant  (hb_grant),
      .hb_req    (hb_req),
      .hb_data   (hb_data),
      .link_up   (link_up),
      .link_lost (link_lost),
      .lock_level(lock_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // One cycle of inputs, applied at a falling edge and held through the next rising edge.
   task automatic applyStimulus(input logic pop, input logic [7:0] data, input logic grant, input logic full);
      rx_pop   = pop;
      rx_data  = data;
      hb_grant = grant;
      tx_full  = full;
      @(negedge clk);
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++)
         applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic sendLockSequence();
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b1, 8'hAF, 1'b0, 1'b0);
         if (k < 2)
            idleCycles(4);
      end
   endtask

   // Behavioural model: link activity expressed as elapsed/idle cycle counts and a lock tally.
   int  mEdges, mLevel, mIdle;
   bit  mReq, mInUp, mLinkUp, mLost;

   always @(posedge clk) begin
      bit periodEnd, accepted, active, expired, isHb, wasUp;
      if (rst) begin
         mEdges = 0; mLevel = 0; mIdle = 0;
         mReq = 0; mInUp = 0; mLinkUp = 0; mLost = 0;
      end else begin
         periodEnd = (mEdges % HB_PERIOD) == HB_PERIOD - 1;
         accepted  = mReq && hb_grant && !tx_full;
         if (periodEnd)
            mReq = 1;
         else if (accepted)
            mReq = 0;
         mEdges++;
         active  = mInUp || (mLevel != 0);
         expired = active && (mIdle == TIMEOUT - 1) && !rx_pop;
         isHb    = rx_pop && (rx_data == 8'hAF);
         wasUp   = mInUp;
         mLost   = 0;
         if (mInUp) begin
            if (expired) begin
               mInUp = 0; mLevel = 0; mLost = 1;
            end
         end else if (mLevel != 0) begin
            if (expired)
               mLevel = 0;
            else if (isHb) begin
               mLevel++;
               if (mLevel == LOCK_CNT)
                  mInUp = 1;
            end else if (rx_pop)
               mLevel = 0;
         end else if (isHb) begin
            mLevel = 1;
            if (LOCK_CNT == 1)
               mInUp = 1;
         end
         mIdle   = (!active || rx_pop || expired) ? 0 : mIdle + 1;
         mLinkUp = wasUp && mInUp;
      end
   end

   always @(posedge clk) begin
      #1;
      checkOutput("hb_req",     {7'b0, hb_req},    {7'b0, mReq});
      checkOutput("hb_data",    hb_data,           mReq ? 8'hAF : 8'h00);
      checkOutput("link_up",    {7'b0, link_up},   {7'b0, mLinkUp});
      checkOutput("link_lost",  {7'b0, link_lost}, {7'b0, mLost});
      checkOutput("lock_level", {4'b0, lock_level}, 8'(mLevel));
   end

   initial begin
      rst = 1'b1; rx_pop = 1'b0; rx_data = 8'h00; hb_grant = 1'b0; tx_full = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("lit_reset_hb_req", {7'b0, hb_req}, 8'h00);
      checkOutput("lit_reset_level", {4'b0, lock_level}, 8'h00);
      rst = 1'b0;

      // First request appears on edge 10, accept on edge 11, next request on edge 20.
      idleCycles(9);
      checkOutput("lit_req_before_10", {7'b0, hb_req}, 8'h00);
      idleCycles(1);
      checkOutput("lit_req_at_10", {7'b0, hb_req}, 8'h01);
      checkOutput("lit_data_at_10", hb_data, 8'hAF);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("lit_req_after_accept", {7'b0, hb_req}, 8'h00);
      checkOutput("lit_data_after_accept", hb_data, 8'h00);
      idleCycles(8);
      checkOutput("lit_req_at_19", {7'b0, hb_req}, 8'h00);
      idleCycles(1);
      checkOutput("lit_req_at_20", {7'b0, hb_req}, 8'h01);

      // Grant held while TX is full across two expiries, then a single accept.
      for (int i = 0; i < 25; i++)
         applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
      checkOutput("lit_req_blocked", {7'b0, hb_req}, 8'h01);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("lit_req_unblocked", {7'b0, hb_req}, 8'h00);
      idleCycles(2);
      checkOutput("lit_req_single_accept", {7'b0, hb_req}, 8'h00);

      // Lock sequence: three heartbeats five cycles apart.
      applyStimulus(1'b1, 8'hAF, 1'b0, 1'b0);
      checkOutput("lit_level_1", {4'b0, lock_level}, 8'h01);
      idleCycles(4);
      applyStimulus(1'b1, 8'hAF, 1'b0, 1'b0);
      checkOutput("lit_level_2", {4'b0, lock_level}, 8'h02);
      idleCycles(4);
      applyStimulus(1'b1, 8'hAF, 1'b0, 1'b0);
      checkOutput("lit_level_3", {4'b0, lock_level}, 8'h03);
      checkOutput("lit_up_not_yet", {7'b0, link_up}, 8'h00);
      idleCycles(1);
      checkOutput("lit_up_after_lock", {7'b0, link_up}, 8'h01);

      // Silence in UP: expiry on the 50th edge after the last byte.
      idleCycles(48);
      checkOutput("lit_up_before_timeout", {7'b0, link_up}, 8'h01);
      checkOutput("lit_lost_before_timeout", {7'b0, link_lost}, 8'h00);
      idleCycles(1);
      checkOutput("lit_lost_pulse", {7'b0, link_lost}, 8'h01);
      checkOutput("lit_up_dropped", {7'b0, link_up}, 8'h00);
      checkOutput("lit_level_cleared", {4'b0, lock_level}, 8'h00);
      idleCycles(1);
      checkOutput("lit_lost_one_cycle", {7'b0, link_lost}, 8'h00);

      // Relock, then a game byte exactly in the expiry cycle keeps the link up.
      sendLockSequence();
      idleCycles(49);
      applyStimulus(1'b1, 8'h05, 1'b0, 1'b0);
      checkOutput("lit_rescue_up", {7'b0, link_up}, 8'h01);
      checkOutput("lit_rescue_no_lost", {7'b0, link_lost}, 8'h00);
      checkOutput("lit_rescue_level", {4'b0, lock_level}, 8'h03);
      idleCycles(49);
      checkOutput("lit_rescue_still_up", {7'b0, link_up}, 8'h01);

      // Reset while UP with a heartbeat pending.
      checkOutput("lit_pre_reset_req", {7'b0, hb_req}, 8'h01);
      rst = 1'b1;
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      rst = 1'b0;
      checkOutput("lit_midreset_req", {7'b0, hb_req}, 8'h00);
      checkOutput("lit_midreset_data", hb_data, 8'h00);
      checkOutput("lit_midreset_up", {7'b0, link_up}, 8'h00);
      checkOutput("lit_midreset_level", {4'b0, lock_level}, 8'h00);

      // Broken lock: a non-heartbeat byte while locking returns to DOWN quietly.
      applyStimulus(1'b1, 8'h33, 1'b0, 1'b0);
      checkOutput("lit_down_ignores_data", {4'b0, lock_level}, 8'h00);
      applyStimulus(1'b1, 8'hAF, 1'b0, 1'b0);
      idleCycles(4);
      applyStimulus(1'b1, 8'hAF, 1'b0, 1'b0);
      idleCycles(4);
      applyStimulus(1'b1, 8'h12, 1'b0, 1'b0);
      checkOutput("lit_broken_level", {4'b0, lock_level}, 8'h00);
      checkOutput("lit_broken_up", {7'b0, link_up}, 8'h00);
      checkOutput("lit_broken_lost", {7'b0, link_lost}, 8'h00);

      // Timeout while LOCKING drops the lock without a lost pulse.
      applyStimulus(1'b1, 8'hAF, 1'b0, 1'b0);
      idleCycles(49);
      checkOutput("lit_locking_before_expiry", {4'b0, lock_level}, 8'h01);
      idleCycles(1);
      checkOutput("lit_locking_expired", {4'b0, lock_level}, 8'h00);
      checkOutput("lit_locking_no_lost", {7'b0, link_lost}, 8'h00);
      idleCycles(5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
